// File: rtl/mem_ctrl_core.sv
// Single-bank SDRAM-style controller: host read/write requests become ACT/RD/WR/PRE
// command sequences over a 64K x 32 array, with periodic refresh inserted from IDLE.
module mem_ctrl_core #(
    parameter int REF_INTERVAL = 780,
    parameter int T_RFC        = 4,
    parameter int T_CAS        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_n,
    input  logic        RDnWR,
    input  logic        Data_in_vld,
    input  logic [15:0] Addr_in,
    input  logic [31:0] Data_in,
    inout  wire  [31:0] DQ,
    output logic [31:0] Data_out,
    output logic        data_out_vld,
    output logic [2:0]  command,
    output logic [3:0]  RA,
    output logic [11:0] CA,
    output logic        cs_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_WR, S_RD, S_CAS_WAIT, S_DATA, S_PRE, S_REFRESH
    } state_t;

    localparam logic [2:0] CMD_NOP = 3'b000;
    localparam logic [2:0] CMD_ACT = 3'b001;
    localparam logic [2:0] CMD_RD  = 3'b010;
    localparam logic [2:0] CMD_WR  = 3'b011;
    localparam logic [2:0] CMD_PRE = 3'b100;
    localparam logic [2:0] CMD_REF = 3'b101;

    localparam int REF_W = $clog2(REF_INTERVAL + 1);

    state_t             r_state;
    logic [REF_W-1:0]   r_ref_cnt;
    logic               r_ref_pend;
    logic [7:0]         r_wait;
    logic [15:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_is_rd;
    logic               r_dq_oe;
    logic               w_ref_tick;
    logic               w_mem_we;
    logic               w_unused_data_in;

    // NOTE: the array is deliberately left out of reset; a reset must not erase stored data,
    // and a resettable 64K-word array could not map onto a RAM macro.
    logic [31:0] r_mem [0:65535] = '{default: 32'h0};

    // Host mirrors Data_in onto DQ; write data is taken from the bus itself.
    assign w_unused_data_in = ^Data_in;

    assign w_ref_tick = (r_ref_cnt == REF_W'(REF_INTERVAL - 1));
    assign w_mem_we   = rst_n && (r_state == S_ACT) && !r_is_rd;
    assign DQ         = r_dq_oe ? Data_out : 'z;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // NOTE: every register here uses <= so all state updates see the pre-edge values,
    // which keeps the simulated behaviour identical to the synthesised flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ref_cnt    <= '0;
            r_ref_pend   <= 1'b0;
            r_wait       <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_rd      <= 1'b0;
            r_dq_oe      <= 1'b0;
            command      <= CMD_NOP;
            cs_n         <= 1'b1;
            RA           <= '0;
            CA           <= '0;
            Data_out     <= '0;
            data_out_vld <= 1'b0;
        end else begin
            r_ref_cnt    <= w_ref_tick ? '0 : r_ref_cnt + 1'b1;
            command      <= CMD_NOP;
            cs_n         <= 1'b1;
            data_out_vld <= 1'b0;
            r_dq_oe      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_ref_pend) begin
                        r_state <= S_REFRESH;
                        command <= CMD_REF;
                        cs_n    <= 1'b0;
                        r_wait  <= 8'(T_RFC - 1);
                    end else if (!cmd_n && (RDnWR || Data_in_vld)) begin
                        r_state <= S_ACT;
                        command <= CMD_ACT;
                        cs_n    <= 1'b0;
                        RA      <= Addr_in[15:12];
                        r_addr  <= Addr_in;
                        r_wdata <= DQ;
                        r_is_rd <= RDnWR;
                    end
                end
                S_ACT: begin
                    r_state <= r_is_rd ? S_RD : S_WR;
                    command <= r_is_rd ? CMD_RD : CMD_WR;
                    cs_n    <= 1'b0;
                    CA      <= r_addr[11:0];
                end
                S_WR: begin
                    r_state <= S_PRE;
                    command <= CMD_PRE;
                    cs_n    <= 1'b0;
                end
                S_RD: begin
                    if (T_CAS > 1) begin
                        r_state <= S_CAS_WAIT;
                        r_wait  <= 8'((T_CAS > 1) ? T_CAS - 2 : 0);
                    end else begin
                        r_state      <= S_DATA;
                        Data_out     <= r_mem[r_addr];
                        data_out_vld <= 1'b1;
                        r_dq_oe      <= 1'b1;
                    end
                end
                S_CAS_WAIT: begin
                    if (r_wait == '0) begin
                        r_state      <= S_DATA;
                        Data_out     <= r_mem[r_addr];
                        data_out_vld <= 1'b1;
                        r_dq_oe      <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                S_DATA: begin
                    r_state <= S_PRE;
                    command <= CMD_PRE;
                    cs_n    <= 1'b0;
                end
                S_PRE: begin
                    r_state <= S_IDLE;
                end
                S_REFRESH: begin
                    if (r_wait == '0) begin
                        r_state    <= S_IDLE;
                        r_ref_pend <= 1'b0;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A new tick outranks the clear so a back-to-back interval is never lost.
            if (w_ref_tick) begin
                r_ref_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl_core.sv
// Self-checking bench for mem_ctrl_core: host model with a read-data scoreboard,
// command-sequence checks, refresh cadence, refresh priority and mid-read reset.
module tb_mem_ctrl_core;

    localparam int REF_INTERVAL = 780;
    localparam int T_RFC        = 4;
    localparam int T_CAS        = 2;

    localparam logic [2:0] C_NOP = 3'b000;
    localparam logic [2:0] C_ACT = 3'b001;
    localparam logic [2:0] C_RD  = 3'b010;
    localparam logic [2:0] C_WR  = 3'b011;
    localparam logic [2:0] C_PRE = 3'b100;
    localparam logic [2:0] C_REF = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_n = 1'b1;
    logic        RDnWR = 1'b0;
    logic        Data_in_vld = 1'b0;
    logic [15:0] Addr_in = '0;
    logic [31:0] Data_in = '0;
    wire  [31:0] DQ;
    logic [31:0] host_dq = '0;
    logic        host_drv = 1'b0;
    logic [31:0] Data_out;
    logic        data_out_vld;
    logic [2:0]  command;
    logic [3:0]  RA;
    logic [11:0] CA;
    logic        cs_n;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb [$];
    logic [31:0] model [int];
    logic [31:0] mon_exp;

    assign DQ = host_drv ? host_dq : 'z;

    mem_ctrl_core #(
        .REF_INTERVAL(REF_INTERVAL),
        .T_RFC       (T_RFC),
        .T_CAS       (T_CAS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_n       (cmd_n),
        .RDnWR       (RDnWR),
        .Data_in_vld (Data_in_vld),
        .Addr_in     (Addr_in),
        .Data_in     (Data_in),
        .DQ          (DQ),
        .Data_out    (Data_out),
        .data_out_vld(data_out_vld),
        .command     (command),
        .RA          (RA),
        .CA          (CA),
        .cs_n        (cs_n)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [15:0] a);
        return model.exists(int'(a)) ? model[int'(a)] : 32'h0;
    endfunction

    // Every data_out_vld pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (data_out_vld) begin
            if (sb.size() == 0) begin
                check("unexpected_vld", 32'd1, 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                check("rd_data", Data_out, mon_exp);
                check("dq_data", DQ, mon_exp);
            end
        end
    end

    task automatic wait_cmd(input logic [2:0] c, input string tag, output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (command == c) begin
                n = i;
                break;
            end
        end
        if (n < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd"},  32'(command), 32'(C_NOP));
        check({tag, "_cs"},   32'(cs_n), 32'd1);
        check({tag, "_ra"},   32'(RA), 32'd0);
        check({tag, "_ca"},   32'(CA), 32'd0);
        check({tag, "_dout"}, Data_out, 32'd0);
        check({tag, "_vld"},  32'(data_out_vld), 32'd0);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic vld);
        int n;
        int hits;
        Addr_in = addr; Data_in = data; host_dq = data; host_drv = 1'b1;
        RDnWR = 1'b0; Data_in_vld = vld; cmd_n = 1'b0;
        if (vld) begin
            wait_cmd(C_ACT, "wr_act", n);
            check("wr_ra", 32'(RA), 32'(addr[15:12]));
            check("wr_act_cs", 32'(cs_n), 32'd0);
            cmd_n = 1'b1; host_drv = 1'b0; Data_in_vld = 1'b0;
            Addr_in = 16'($urandom); Data_in = $urandom; host_dq = $urandom;
            @(negedge clk);
            check("wr_cmd", 32'(command), 32'(C_WR));
            check("wr_ca", 32'(CA), 32'(addr[11:0]));
            @(negedge clk);
            check("wr_pre", 32'(command), 32'(C_PRE));
            @(negedge clk);
            check("wr_nop", 32'(command), 32'(C_NOP));
            check("wr_nop_cs", 32'(cs_n), 32'd1);
            check("nop_ra_hold", 32'(RA), 32'(addr[15:12]));
            model[int'(addr)] = data;
        end else begin
            hits = 0;
            repeat (6) begin
                @(negedge clk);
                if (command == C_ACT || command == C_WR) hits++;
            end
            check("nowr_cmds", 32'(hits), 32'd0);
            cmd_n = 1'b1; host_drv = 1'b0;
        end
    endtask

    task automatic do_read(input logic [15:0] addr, input logic prio);
        int n;
        int lat;
        logic [31:0] exp;
        exp = model_rd(addr);
        Addr_in = addr; RDnWR = 1'b1; Data_in_vld = 1'b0; cmd_n = 1'b0;
        if (prio) begin
            @(negedge clk);
            check("prio_ref", 32'(command), 32'(C_REF));
            check("prio_ref_cs", 32'(cs_n), 32'd0);
            wait_cmd(C_ACT, "prio_act", n);
            check("ref_to_act", 32'(n), 32'(T_RFC + 1));
        end else begin
            wait_cmd(C_ACT, "rd_act", n);
        end
        check("rd_ra", 32'(RA), 32'(addr[15:12]));
        check("rd_act_cs", 32'(cs_n), 32'd0);
        cmd_n = 1'b1; Addr_in = 16'($urandom);
        @(negedge clk);
        check("rd_cmd", 32'(command), 32'(C_RD));
        check("rd_ca", 32'(CA), 32'(addr[11:0]));
        sb.push_back(exp);
        lat = 1;
        while (!data_out_vld && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rd_latency", 32'(lat), 32'd3);
        @(negedge clk);
        check("vld_one_cycle", 32'(data_out_vld), 32'd0);
        check("dout_hold", Data_out, exp);
        check("rd_pre", 32'(command), 32'(C_PRE));
        @(negedge clk);
        check("rd_nop", 32'(command), 32'(C_NOP));
    endtask

    initial begin
        int n;
        int refs;
        logic [15:0] a;
        logic [31:0] d;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst_n = 1'b1;
        @(negedge clk);

        // cmd_n held low across a full write: the same write is accepted again.
        Addr_in = 16'h5000; Data_in = 32'h0BADF00D; host_dq = 32'h0BADF00D; host_drv = 1'b1;
        RDnWR = 1'b0; Data_in_vld = 1'b1; cmd_n = 1'b0;
        wait_cmd(C_ACT, "rewr_act0", n);
        wait_cmd(C_ACT, "rewr_act1", n);
        check("rewr_gap", 32'(n), 32'd4);
        cmd_n = 1'b1; host_drv = 1'b0; Data_in_vld = 1'b0;
        repeat (4) @(negedge clk);
        model[32'h5000] = 32'h0BADF00D;
        do_read(16'h5000, 1'b0);

        do_write(16'h1001, 32'hA5A5A5A5, 1'b1);
        do_read(16'h1001, 1'b0);
        do_write(16'h2000, 32'hDEADBEEF, 1'b1);
        do_read(16'h2000, 1'b0);
        do_read(16'h1001, 1'b0);
        do_write(16'h3000, 32'h12345678, 1'b0);
        do_read(16'h3000, 1'b0);

        for (int i = 0; i < 3; i++) begin
            a = {4'(6 + i), 12'($urandom)};
            d = $urandom;
            do_write(a, d, 1'b1);
            do_read(a, 1'b0);
        end

        repeat (20) @(negedge clk);
        refs = 0;
        repeat (2 * REF_INTERVAL) begin
            @(negedge clk);
            if (command == C_REF) begin
                refs++;
                check("ref_cs", 32'(cs_n), 32'd0);
            end
        end
        check("ref_count", 32'(refs), 32'd2);
        do_read(16'h1001, 1'b0);
        do_read(16'h2000, 1'b0);

        // Reset while the read sits in CAS_WAIT: no data pulse may follow.
        Addr_in = 16'h2000; RDnWR = 1'b1; cmd_n = 1'b0;
        wait_cmd(C_ACT, "abort_act", n);
        cmd_n = 1'b1;
        @(negedge clk);
        check("abort_rd", 32'(command), 32'(C_RD));
        @(negedge clk);
        check("abort_cas_nop", 32'(command), 32'(C_NOP));
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;

        // Refresh becomes pending exactly REF_INTERVAL edges after the last reset edge.
        repeat (REF_INTERVAL) @(negedge clk);
        do_read(16'h1001, 1'b1);

        repeat (10) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_core.md
MEM_CTRL_CORE -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have the parameter REF_INTERVAL, default 780, meaning clock cycles between refresh requests.
REQ-002 The block SHALL have the parameter T_RFC, default 4, meaning cycles spent in the REFRESH state.
REQ-003 The block SHALL have the parameter T_CAS, default 2, meaning cycles from READ command to data.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with ports named as below.
REQ-005 clk  input  1  rising-edge clock for all logic.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 cmd_n  input  1  active-low request strobe, level-sampled.
REQ-008 RDnWR  input  1  request type: 1 = read, 0 = write.
REQ-009 Data_in_vld  input  1  write data valid; a write without it is discarded.
REQ-010 Addr_in  input  16  request address: [15:12] = row, [11:0] = column.
REQ-011 Data_in  input  32  host write data; the host mirrors it onto DQ.
REQ-012 DQ  inout  32  bidirectional data bus.
REQ-013 Data_out  output  32  read data, held until the next read completes.
REQ-014 data_out_vld  output  1  one-cycle pulse when Data_out updates.
REQ-015 command  output  3  issued command: 000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE, 101 REF.
REQ-016 RA  output  4  row address of the last ACT.
REQ-017 CA  output  12  column address of the last RD/WR.
REQ-018 cs_n  output  1  chip select, 0 whenever command is not NOP.

Function
REQ-019 The block SHALL contain a 65536 x 32 storage array indexed by Addr_in, initialised to 0 at time zero and not cleared by reset.
REQ-020 The state machine SHALL have the states IDLE, ACT, WR, RD, CAS_WAIT, DATA, PRE and REFRESH.
REQ-021 The block SHALL register every output, so each state's outputs appear in the cycle after that state is entered.
REQ-022 In IDLE, a pending refresh SHALL have priority over a request sampled in the same cycle.
REQ-023 In IDLE with cmd_n=0 and RDnWR=1, the block SHALL accept a read and latch Addr_in.
REQ-024 In IDLE with cmd_n=0, RDnWR=0 and Data_in_vld=1, the block SHALL accept a write and latch Addr_in and DQ.
REQ-025 A write request with Data_in_vld=0 SHALL be ignored: no command is issued and the array is unchanged.
REQ-026 The write sequence SHALL be IDLE->ACT (command=001, RA=row)->WR (command=011, CA=col, latched data written to the array)->PRE (command=100)->IDLE, 4 cycles.
REQ-027 The read sequence SHALL be IDLE->ACT->RD (command=010, CA=col)->CAS_WAIT for T_CAS-1 cycles->DATA->PRE->IDLE.
REQ-028 In DATA, Data_out SHALL take the array word, data_out_vld SHALL be 1 for exactly one cycle, and DQ SHALL be driven with that word for that cycle only.
REQ-029 With default parameters, data_out_vld SHALL be high in the 4th cycle after the accepting edge.
REQ-030 DQ SHALL be high-impedance in every state except DATA.
REQ-031 Requests SHALL be accepted only in IDLE; cmd_n pulses arriving in other states are dropped.
REQ-032 If cmd_n stays low, the request SHALL be re-accepted on return to IDLE; a repeated write is idempotent.
REQ-033 Inputs other than cmd_n, RDnWR and Data_in_vld SHALL be ignored after acceptance.
REQ-034 A free-running counter SHALL raise refresh-pending every REF_INTERVAL cycles.
REQ-035 When refresh-pending is served, the block SHALL issue REF (command=101) for one cycle, stay in REFRESH for T_RFC cycles, clear pending, and return to IDLE.
REQ-036 A refresh SHALL never interrupt an active sequence; it waits for IDLE.
REQ-037 In NOP cycles, RA and CA SHALL hold their last values.

Reset
REQ-038 rst_n=0 at a rising edge SHALL force IDLE, command=000, cs_n=1, RA=0, CA=0, Data_out=0, data_out_vld=0, DQ=Z, and clear the refresh counter and pending flag.
REQ-039 Reset asserted mid-sequence SHALL abort the sequence; a WR state already completed stays in the array, otherwise the array is unchanged.

Verification
REQ-040 Write 0x1001/0xA5A5A5A5 with Data_in_vld=1, then read 0x1001 -> command sequence ACT(RA=1), RD(CA=0x001); data_out_vld pulse; Data_out=0xA5A5A5A5.
REQ-041 Write 0x2000/0xDEADBEEF, then read 0x2000 -> RA=2, CA=0x000; Data_out=0xDEADBEEF; a re-read of 0x1001 still returns 0xA5A5A5A5.
REQ-042 Write 0x3000/0x12345678 with Data_in_vld=0, then read 0x3000 -> no ACT/WR for that write; Data_out=0x00000000.
REQ-043 Idle for more than REF_INTERVAL cycles -> exactly one REF with cs_n=0 per interval; reads of 0x1001 and 0x2000 afterwards are unchanged.
REQ-044 Assert rst_n=0 during CAS_WAIT of a read -> next cycle all outputs at reset values, no data_out_vld pulse.
REQ-045 Read request arriving in the cycle a refresh becomes pending -> REF is issued first and the read completes after T_RFC cycles with correct data.
